axis_out_buffer_writer: RTL and testbench
=========================================

// Module: axis_out_buffer_writer
// PURPOSE
//  Sink for the engine's output AXI-Stream (LF width, byte tkeep, tlast, bytes-per-transfer tuser).
//  Packs the valid bytes of each beat into OUT_BITS words and writes them sequentially into an
//  on-chip output RAM. The host reads results back over a simple port once done is raised.
//  Sits directly downstream of the engine's output width adapter.
// PARAMETERS
//  S_DATA_WIDTH    128  stream data width in bits (= M_OUTPUT_WIDTH_LF); multiple of OUT_BITS
//  W_BPT           8    width of bytes-per-transfer sideband
//  OUT_BITS        32   RAM word width in bits; OUT_BYTES = OUT_BITS/8
//  OUT_ADDR_WIDTH  10   RAM depth = 2**OUT_ADDR_WIDTH words
// PORTS
//  aclk                 in   1               clock
//  aresetn              in   1               async active-low reset
//  arm                  in   1               pulse: start capture of one packet at RAM addr 0
//  s_axis_tready        out  1               stream ready
//  s_axis_tvalid        in   1               stream valid
//  s_axis_tlast         in   1               last beat of packet
//  s_axis_tdata         in   S_DATA_WIDTH    data, byte 0 in bits [7:0]
//  s_axis_tkeep         in   S_DATA_WIDTH/8  byte enables
//  s_bytes_per_transfer in   W_BPT           tuser sideband
//  rd_addr              in   OUT_ADDR_WIDTH  host read address
//  rd_data              out  OUT_BITS        host read data, 1-cycle latency
//  busy / done          out  1 / 1           capture in progress / packet fully written (sticky)
//  overflow / keep_err  out  1 / 1           sticky error flags
//  word_count           out  OUT_ADDR_WIDTH+1  words written this packet (saturating)
//  last_bpt             out  W_BPT           bytes-per-transfer of last accepted beat
// BEHAVIOUR
//  Reset: state IDLE; tready, busy, done, overflow, keep_err = 0; word_count, last_bpt = 0;
//   residual byte buffer emptied; RAM contents undefined; rd_data = 0.
//  FSM IDLE -> RECV on arm; RECV -> FLUSH on accepted tlast; FLUSH -> DONE when residual empty
//   and final write issued; DONE -> RECV on arm. arm in RECV/FLUSH ignored.
//  On arm: wr_addr, word_count, done, overflow, keep_err cleared; residual emptied.
//  Beat byte count n = number of consecutive 1s in tkeep from bit 0. Any 1 above the first 0
//   sets keep_err; those bytes are dropped. tkeep==0 contributes no bytes (tlast still honoured).
//  Residual buffer holds up to S_DATA_WIDTH/8+OUT_BYTES-1 bytes, byte-ordered FIFO-style.
//  tready = (state==RECV) && (residual < OUT_BYTES). Handshake = tvalid&&tready; n bytes appended.
//  Each cycle residual >= OUT_BYTES: lowest OUT_BYTES bytes written to RAM[wr_addr] (registered,
//   write occurs cycle after the bytes become available), wr_addr++, word_count++.
//  Full-width beat => S_DATA_WIDTH/OUT_BITS cycles per beat; sustained 1 word/cycle.
//  FLUSH: full words drained first; a final 1..OUT_BYTES-1 byte remainder written zero-padded in
//   upper bytes. done rises the cycle after the last RAM write; busy = RECV|FLUSH.
//  Overflow: write when wr_addr already wrapped (word_count == 2**OUT_ADDR_WIDTH) is suppressed,
//   overflow set; stream still accepted until tlast so engine never stalls; no wrap-around write.
//  last_bpt captured on every handshake. rd port independent of write port; reading an address
//   written in the same cycle returns old data.
//  Reset mid-packet: immediate return to IDLE, partial data discarded, upstream sees tready=0.
// STRUCTURE
//  Shared package: OUT_BYTES, state enum {IDLE,RECV,FLUSH,DONE}, S_BYTES = S_DATA_WIDTH/8.
//  Sub-module out_ram_sdp: simple dual-port RAM, one write port, one registered read port.
//  Packer/FSM in this module.
// TESTING
//  arm; one beat, tkeep=16'hFFFF, data bytes 0..15, tlast -> RAM[0..3]=03020100,07060504,
//   0B0A0908,0F0E0D0C; word_count=4; done 1 cycle after last write; tready low 3 of 4 cycles.
//  arm; beats with tkeep 16'h003F then 16'h001F+tlast (11 bytes 0..10) -> RAM[0]=03020100,
//   RAM[1]=07060504, RAM[2]=000A0908; word_count=3.
//  tkeep=16'h00F5 on a beat -> keep_err=1, only byte 0 kept; next arm clears keep_err.
//  OUT_ADDR_WIDTH=2, arm, stream 6 full words + tlast -> RAM[0..3] written, overflow=1,
//   word_count=4, done=1, tready never stuck low.
//  aresetn low mid-packet after 2 beats -> all flags 0, tready 0; arm + fresh packet captured at addr 0.
//  Random tvalid gaps and random contiguous tkeep, 200 packets vs byte-accurate model -> exact RAM match.

Source files
------------

// File: rtl/axis_out_buffer_writer_pkg.sv
// Shared definitions for the output buffer writer.
// - default parameter values for the stream and RAM geometry
// - S_BYTES / OUT_BYTES byte counts for the default geometry
// - capture FSM state encoding
// - helper that sizes the residual byte buffer
package axis_out_buffer_writer_pkg;

  localparam int DEF_S_DATA_WIDTH   = 128;
  localparam int DEF_W_BPT          = 8;
  localparam int DEF_OUT_BITS       = 32;
  localparam int DEF_OUT_ADDR_WIDTH = 10;

  localparam int OUT_BYTES = DEF_OUT_BITS / 8;
  localparam int S_BYTES   = DEF_S_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Worst case: OUT_BYTES-1 bytes left over, then a full beat appended.
  function automatic int residual_bytes(input int s_bytes, input int out_bytes);
    return s_bytes + out_bytes - 1;
  endfunction

endpackage

// File: rtl/axis_out_buffer_writer_if.sv
// AXI-Stream bundle feeding the output buffer writer.
// Signals: tready (sink->source), tvalid, tlast, tdata, tkeep, bytes_per_transfer (tuser).
// Modports: master = stream source, slave = stream sink.
interface axis_out_buffer_writer_if
  import axis_out_buffer_writer_pkg::*;
#(
  parameter int S_DATA_WIDTH = DEF_S_DATA_WIDTH,
  parameter int W_BPT        = DEF_W_BPT
);

  logic                      tready;
  logic                      tvalid;
  logic                      tlast;
  logic [S_DATA_WIDTH-1:0]   tdata;
  logic [S_DATA_WIDTH/8-1:0] tkeep;
  logic [W_BPT-1:0]          bytes_per_transfer;

  modport master (
    input  tready,
    output tvalid, tlast, tdata, tkeep, bytes_per_transfer
  );

  modport slave (
    output tready,
    input  tvalid, tlast, tdata, tkeep, bytes_per_transfer
  );

endinterface

// File: rtl/axis_out_buffer_writer_ram.sv
// Simple dual-port output RAM: one write port, one registered read port.
// Ports: clk, rst_n (clears only the read register), we/wr_addr/wr_data,
//        rd_addr/rd_data (1-cycle latency, read-during-write returns old data).
module out_ram_sdp
  import axis_out_buffer_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_OUT_BITS,
  parameter int ADDR_WIDTH = DEF_OUT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_reg <= '0;
    else        rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/axis_out_buffer_writer.sv
// Output stream sink: packs the valid bytes of each AXI-Stream beat into
// OUT_BITS words and writes them sequentially into an on-chip RAM from addr 0.
// Ports: aclk, aresetn (async, active low), arm (start one packet capture),
//        s_axis (stream slave), rd_addr/rd_data (host readback, 1-cycle latency),
//        busy, done (sticky until next arm), overflow, keep_err (sticky),
//        word_count (words written, saturating), last_bpt (tuser of last beat).
module axis_out_buffer_writer
  import axis_out_buffer_writer_pkg::*;
#(
  parameter int S_DATA_WIDTH   = DEF_S_DATA_WIDTH,
  parameter int W_BPT          = DEF_W_BPT,
  parameter int OUT_BITS       = DEF_OUT_BITS,
  parameter int OUT_ADDR_WIDTH = DEF_OUT_ADDR_WIDTH
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      arm,
  axis_out_buffer_writer_if.slave   s_axis,
  input  logic [OUT_ADDR_WIDTH-1:0] rd_addr,
  output logic [OUT_BITS-1:0]       rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      keep_err,
  output logic [OUT_ADDR_WIDTH:0]   word_count,
  output logic [W_BPT-1:0]          last_bpt
);

  localparam int SBYTES    = S_DATA_WIDTH / 8;
  localparam int OBYTES    = OUT_BITS / 8;
  localparam int RES_BYTES = residual_bytes(SBYTES, OBYTES);
  localparam int RES_BITS  = RES_BYTES * 8;
  localparam int CW        = $clog2(RES_BYTES + 1);
  localparam int NW        = $clog2(SBYTES + 1);

  state_t state_reg, state_next;

  // Residual bytes are kept LSB-aligned; bytes above res_cnt_reg are always zero,
  // which makes the zero-padded final remainder fall out for free.
  logic [RES_BITS-1:0]       res_reg, res_next, res_after_pop, append;
  logic [CW-1:0]             res_cnt_reg, cnt_next, cnt_after_pop, pop_bytes;
  logic                      wr_en_reg;
  logic [OUT_BITS-1:0]       wr_data_reg;
  logic [OUT_ADDR_WIDTH-1:0] wr_addr_reg;
  logic [OUT_ADDR_WIDTH:0]   word_count_reg;
  logic                      overflow_reg, keep_err_reg;
  logic [W_BPT-1:0]          last_bpt_reg;

  logic [NW-1:0]             keep_len;
  logic                      keep_gap, keep_bad;
  logic [S_DATA_WIDTH-1:0]   data_masked;
  logic                      full_avail, pop, handshake, arm_go, ram_full;
  logic                      tready_int, busy_int, done_int;

  // Leading run of ones in tkeep; any set bit after the first hole is an error.
  always_comb begin
    keep_len = '0;
    keep_gap = 1'b0;
    keep_bad = 1'b0;
    for (int i = 0; i < SBYTES; i++) begin
      if (!s_axis.tkeep[i])  keep_gap = 1'b1;
      else if (keep_gap)     keep_bad = 1'b1;
      else                   keep_len = keep_len + NW'(1);
    end
  end

  for (genvar gi = 0; gi < SBYTES; gi++) begin : g_mask
    assign data_masked[gi*8 +: 8] = (NW'(gi) < keep_len) ? s_axis.tdata[gi*8 +: 8] : 8'h00;
  end

  assign full_avail = (res_cnt_reg >= CW'(OBYTES));
  assign arm_go     = arm && ((state_reg == IDLE) || (state_reg == DONE));
  assign ram_full   = word_count_reg[OUT_ADDR_WIDTH];

  // RECV drains full words only; FLUSH also drains the short tail.
  always_comb begin
    pop = 1'b0;
    if (state_reg == RECV)       pop = full_avail;
    else if (state_reg == FLUSH) pop = (res_cnt_reg != '0);
    pop_bytes     = full_avail ? CW'(OBYTES) : res_cnt_reg;
    cnt_after_pop = pop ? (res_cnt_reg - pop_bytes) : res_cnt_reg;
    res_after_pop = pop ? (res_reg >> OUT_BITS) : res_reg;
  end

  assign handshake = s_axis.tvalid && tready_int;
  assign append    = handshake ? (RES_BITS'(data_masked) << {cnt_after_pop, 3'b000}) : '0;
  assign res_next  = res_after_pop | append;
  assign cnt_next  = cnt_after_pop + (handshake ? CW'(keep_len) : CW'(0));

  // FSM: state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (arm) state_next = RECV;
      RECV:       if (handshake && s_axis.tlast) state_next = FLUSH;
      // An empty residual means the last word is at most in the write register,
      // which commits on the same edge that enters DONE.
      FLUSH:      if (res_cnt_reg == '0) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // FSM: outputs. Ready looks at the residual after this cycle's drain so a
  // full-width beat can be accepted back-to-back at one word per cycle.
  always_comb begin
    tready_int = 1'b0;
    busy_int   = 1'b0;
    done_int   = 1'b0;
    case (state_reg)
      RECV: begin
        busy_int   = 1'b1;
        tready_int = (cnt_after_pop < CW'(OBYTES));
      end
      FLUSH:   busy_int = 1'b1;
      DONE:    done_int = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      res_reg        <= '0;
      res_cnt_reg    <= '0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= '0;
      wr_addr_reg    <= '0;
      word_count_reg <= '0;
      overflow_reg   <= 1'b0;
      keep_err_reg   <= 1'b0;
      last_bpt_reg   <= '0;
    end else begin
      wr_en_reg <= pop;
      if (pop) wr_data_reg <= res_reg[OUT_BITS-1:0];
      if (arm_go) begin
        res_reg        <= '0;
        res_cnt_reg    <= '0;
        wr_addr_reg    <= '0;
        word_count_reg <= '0;
        overflow_reg   <= 1'b0;
        keep_err_reg   <= 1'b0;
      end else begin
        res_reg     <= res_next;
        res_cnt_reg <= cnt_next;
        if (handshake) begin
          last_bpt_reg <= s_axis.bytes_per_transfer;
          if (keep_bad) keep_err_reg <= 1'b1;
        end
        // Once the RAM has been filled, further words are dropped rather than wrapped.
        if (wr_en_reg) begin
          if (ram_full) begin
            overflow_reg <= 1'b1;
          end else begin
            wr_addr_reg    <= wr_addr_reg + 1'b1;
            word_count_reg <= word_count_reg + 1'b1;
          end
        end
      end
    end
  end

  out_ram_sdp #(
    .DATA_WIDTH(OUT_BITS),
    .ADDR_WIDTH(OUT_ADDR_WIDTH)
  ) u_ram (
    .clk     (aclk),
    .rst_n   (aresetn),
    .we      (wr_en_reg && !ram_full),
    .wr_addr (wr_addr_reg),
    .wr_data (wr_data_reg),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign s_axis.tready = tready_int;
  assign busy          = busy_int;
  assign done          = done_int;
  assign overflow      = overflow_reg;
  assign keep_err      = keep_err_reg;
  assign word_count    = word_count_reg;
  assign last_bpt      = last_bpt_reg;

endmodule

// File: tb/tb_axis_out_buffer_writer.sv
// Bench for axis_out_buffer_writer: a default-size instance (a) and a 4-word
// RAM instance (b) share the stream stimulus; sel picks which one is active.
module tb_axis_out_buffer_writer;
  import axis_out_buffer_writer_pkg::*;

  localparam int SW = 128;
  localparam int SB = S_BYTES;

  logic aclk = 1'b0, aresetn = 1'b0, arm_a = 1'b0, arm_b = 1'b0;
  logic tvalid = 1'b0, tlast = 1'b0;
  logic [SW-1:0] tdata = '0;
  logic [SB-1:0] tkeep = '0;
  logic [7:0] bpt = '0;
  logic [9:0] rd_addr_a = '0;
  logic [1:0] rd_addr_b = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic busy_a, done_a, ovf_a, kerr_a, busy_b, done_b, ovf_b, kerr_b;
  logic [10:0] wc_a;
  logic [2:0]  wc_b;
  logic [7:0]  lbpt_a, lbpt_b;

  int total = 0, bad = 0;
  bit sel = 1'b0;
  logic [7:0]  pkt_bytes[$];
  logic [31:0] exp_words[$];

  axis_out_buffer_writer_if #(.S_DATA_WIDTH(SW), .W_BPT(8)) ifa ();
  axis_out_buffer_writer_if #(.S_DATA_WIDTH(SW), .W_BPT(8)) ifb ();
  assign ifa.tvalid = tvalid; assign ifa.tlast = tlast; assign ifa.tdata = tdata;
  assign ifa.tkeep = tkeep;   assign ifa.bytes_per_transfer = bpt;
  assign ifb.tvalid = tvalid; assign ifb.tlast = tlast; assign ifb.tdata = tdata;
  assign ifb.tkeep = tkeep;   assign ifb.bytes_per_transfer = bpt;

  axis_out_buffer_writer #(.S_DATA_WIDTH(SW), .W_BPT(8), .OUT_BITS(32), .OUT_ADDR_WIDTH(10)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .arm(arm_a), .s_axis(ifa),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .keep_err(kerr_a), .word_count(wc_a), .last_bpt(lbpt_a));

  axis_out_buffer_writer #(.S_DATA_WIDTH(SW), .W_BPT(8), .OUT_BITS(32), .OUT_ADDR_WIDTH(2)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .arm(arm_b), .s_axis(ifb),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .keep_err(kerr_b), .word_count(wc_b), .last_bpt(lbpt_b));

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_tready(); return sel ? ifb.tready : ifa.tready; endfunction
  function automatic logic cur_done();   return sel ? done_b : done_a;         endfunction
  function automatic logic [10:0] cur_wc(); return sel ? 11'(wc_b) : wc_a;     endfunction

  task automatic do_arm();
    @(negedge aclk);
    if (sel) arm_b = 1'b1; else arm_a = 1'b1;
    @(negedge aclk);
    arm_a = 1'b0; arm_b = 1'b0;
  endtask

  // Drives one beat until accepted; records its kept bytes in the byte model.
  task automatic send_beat(input logic [SW-1:0] d, input logic [SB-1:0] k, input bit l,
                           input logic [7:0] b, output int waits);
    int n;
    tdata = d; tkeep = k; tlast = l; bpt = b; tvalid = 1'b1;
    waits = 0;
    while (!cur_tready() && waits < 100) begin
      @(negedge aclk);
      waits++;
    end
    if (waits >= 100) begin
      total++; bad++;
      $error("FAIL tready_timeout observed=stuck_low expected=ready_within_100");
    end
    @(negedge aclk);
    tvalid = 1'b0;
    n = 0;
    while (n < SB && k[n]) n++;
    for (int i = 0; i < n; i++) pkt_bytes.push_back(d[i*8 +: 8]);
  endtask

  task automatic model_finish();
    logic [31:0] w;
    while (pkt_bytes.size() > 0) begin
      w = '0;
      for (int i = 0; i < 4; i++)
        if (pkt_bytes.size() > 0) w[i*8 +: 8] = pkt_bytes.pop_front();
      exp_words.push_back(w);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!cur_done() && cyc < 500) begin
      @(negedge aclk);
      cyc++;
    end
    if (cyc >= 500) begin
      total++; bad++;
      $error("FAIL done_timeout observed=done_low expected=done_within_500");
    end
  endtask

  task automatic read_word(input int addr, output logic [31:0] data);
    if (sel) rd_addr_b = addr[1:0]; else rd_addr_a = addr[9:0];
    @(negedge aclk);
    data = sel ? rd_data_b : rd_data_a;
  endtask

  task automatic check_ram(input string tag);
    logic [31:0] e, got;
    int a = 0;
    while (exp_words.size() > 0) begin
      e = exp_words.pop_front();
      read_word(a, got);
      chk($sformatf("%s_ram%0d", tag, a), got, e);
      a++;
    end
  endtask

  function automatic logic [SW-1:0] seq_data(input int start);
    logic [SW-1:0] d;
    for (int i = 0; i < SB; i++) d[i*8 +: 8] = 8'(start + i);
    return d;
  endfunction

  initial begin
    int w, cyc, nb, len, exp_wc;
    logic [SW-1:0] d;
    logic [SB-1:0] k;

    // Reset state
    repeat (2) @(negedge aclk);
    chk("rst_tready", ifa.tready, 1'b0);
    chk("rst_flags", {busy_a, done_a, ovf_a, kerr_a}, 4'b0000);
    chk("rst_wc", wc_a, 11'd0);
    chk("rst_bpt", lbpt_a, 8'd0);
    chk("rst_rd", rd_data_a, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_tready", ifa.tready, 1'b0);

    // Single full beat, done latency
    sel = 1'b0;
    do_arm();
    chk("arm_busy", busy_a, 1'b1);
    send_beat(seq_data(0), 16'hFFFF, 1'b1, 8'd16, w);
    pkt_bytes.delete();
    exp_words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    wait_done(cyc);
    chk("t1_done_latency", cyc, 5);
    chk("t1_wc", wc_a, 11'd4);
    check_ram("t1");

    // Back-to-back full beats: one accepted every 4 cycles
    do_arm();
    send_beat(seq_data(8'h20), 16'hFFFF, 1'b0, 8'd16, w);
    send_beat(seq_data(8'h40), 16'hFFFF, 1'b0, 8'd16, w);
    chk("tput_wait2", w, 3);
    send_beat(seq_data(8'h60), 16'hFFFF, 1'b1, 8'd16, w);
    chk("tput_wait3", w, 3);
    model_finish();
    wait_done(cyc);
    chk("tput_wc", wc_a, 11'd12);
    check_ram("tput");

    // Partial beats with zero-padded tail; garbage in dropped lanes
    do_arm();
    d = {SW{1'b1}} ^ seq_data(8'hE0);
    for (int i = 0; i < 6; i++) d[i*8 +: 8] = 8'(i);
    send_beat(d, 16'h003F, 1'b0, 8'd6, w);
    for (int i = 0; i < 5; i++) d[i*8 +: 8] = 8'(i + 6);
    send_beat(d, 16'h001F, 1'b1, 8'd5, w);
    pkt_bytes.delete();
    exp_words = '{32'h03020100, 32'h07060504, 32'h000A0908};
    wait_done(cyc);
    chk("t2_wc", wc_a, 11'd3);
    chk("t2_last_bpt", lbpt_a, 8'd5);
    chk("t2_keep_err", kerr_a, 1'b0);
    check_ram("t2");

    // Non-contiguous tkeep
    do_arm();
    d = seq_data(8'h5A);
    send_beat(d, 16'h00F5, 1'b1, 8'd1, w);
    model_finish();
    wait_done(cyc);
    chk("kerr_set", kerr_a, 1'b1);
    chk("kerr_wc", wc_a, 11'd1);
    chk("kerr_word", exp_words[0], 32'h0000005A);
    check_ram("kerr");
    do_arm();
    chk("kerr_cleared", kerr_a, 1'b0);
    chk("rearm_done_low", done_a, 1'b0);
    // Empty packet: tlast with no bytes
    send_beat(seq_data(0), 16'h0000, 1'b1, 8'd0, w);
    wait_done(cyc);
    chk("empty_wc", wc_a, 11'd0);

    // Overflow on the 4-word instance: 6 words streamed
    sel = 1'b1;
    do_arm();
    send_beat(seq_data(8'h80), 16'hFFFF, 1'b0, 8'd16, w);
    send_beat(seq_data(8'hC0), 16'h00FF, 1'b1, 8'd8, w);
    pkt_bytes.delete();
    exp_words = '{32'h83828180, 32'h87868584, 32'h8B8A8988, 32'h8F8E8D8C};
    wait_done(cyc);
    chk("ovf_flag", ovf_b, 1'b1);
    chk("ovf_wc", wc_b, 3'd4);
    chk("ovf_done", done_b, 1'b1);
    check_ram("ovf");

    // Reset in the middle of a packet
    sel = 1'b0;
    do_arm();
    send_beat(seq_data(8'h10), 16'hFFFF, 1'b0, 8'd16, w);
    send_beat(seq_data(8'h30), 16'hFFFF, 1'b0, 8'd16, w);
    pkt_bytes.delete();
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tready", ifa.tready, 1'b0);
    chk("mid_rst_flags", {busy_a, done_a, ovf_a, kerr_a}, 4'b0000);
    chk("mid_rst_wc", wc_a, 11'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    do_arm();
    send_beat(seq_data(8'hA0), 16'h00FF, 1'b1, 8'd8, w);
    model_finish();
    wait_done(cyc);
    chk("post_rst_wc", wc_a, 11'd2);
    check_ram("post_rst");

    // Random packets against the byte model
    for (int p = 0; p < 200; p++) begin
      do_arm();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge aclk);
        len = $urandom_range(0, SB);
        k = (len == SB) ? {SB{1'b1}} : SB'((17'd1 << len) - 17'd1);
        d = {$urandom, $urandom, $urandom, $urandom};
        send_beat(d, k, (b == nb - 1), 8'(len), w);
      end
      model_finish();
      exp_wc = exp_words.size();
      wait_done(cyc);
      chk($sformatf("rnd%0d_wc", p), cur_wc(), 11'(exp_wc));
      check_ram($sformatf("rnd%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
